// File: rtl/sprite_cmd_sequencer.sv
// sprite_cmd_sequencer: serializes a host-loaded sprite descriptor table into 32-bit command words once per frame.
// Define SEQ_SKIP_HIDDEN_EN to emit only the type-1 word for enabled entries whose visible bit is clear.
module sprite_cmd_sequencer #(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [48:0]      ld_data,
    input  logic             frame_start,
    output logic [31:0]      cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_overrun,
    output logic             front_buf
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, FLUSH} state_t;
    state_t state, state_n;
    logic [NUM_ENTRIES-1:0] en_tbl;
    logic [47:0] tbl [NUM_ENTRIES];
    logic [47:0] work;
    logic [IDX_W-1:0] idx;
    logic [1:0] cnt;
    logic pending, accept, flush_acc, restart, last_idx, last_word;
    logic [12:0] msg;

    assign accept = cmd_valid && cmd_ready;
    assign flush_acc = state == FLUSH && cmd_ready;
    assign restart = flush_acc && (pending || frame_start);
    assign last_idx = idx == IDX_W'(NUM_ENTRIES - 1);
`ifdef SEQ_SKIP_HIDDEN_EN
    assign last_word = cnt == 2'd3 || (cnt == 2'd0 && !work[36]);
`else
    assign last_word = cnt == 2'd3;
`endif

    // Descriptor payload needs no reset; only the enable bits are cleared.
    always_ff @(posedge clk) begin
        if (ld_en) tbl[ld_idx] <= ld_data[47:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) en_tbl <= '0;
        else if (ld_en) en_tbl[ld_idx] <= ld_data[48];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            work <= '0;
            pending <= 1'b0;
            front_buf <= 1'b0;
            frame_done <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state <= state_n;
            frame_done <= flush_acc;
            frame_overrun <= frame_start && busy && pending && !flush_acc;
            // A request landing on the flush accept starts the next frame directly.
            pending <= flush_acc ? pending && frame_start : pending || (frame_start && busy);
            if (flush_acc) front_buf <= ~front_buf;
            if (state == IDLE || restart) idx <= '0;
            else if ((state == FETCH && !en_tbl[idx]) || (state == SEND && accept && last_word)) idx <= idx + 1'b1;
            if (state == FETCH) begin
                work <= tbl[idx];
                cnt <= '0;
            end else if (state == SEND && accept) cnt <= cnt + 2'd1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = frame_start ? FETCH : IDLE;
            FETCH: state_n = en_tbl[idx] ? SEND : last_idx ? FLUSH : FETCH;
            SEND:  state_n = accept && last_word ? (last_idx ? FLUSH : FETCH) : SEND;
            FLUSH: state_n = flush_acc ? (restart ? FETCH : IDLE) : FLUSH;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        cmd_valid = state == SEND || state == FLUSH;
        msg = cnt == 2'd0 ? {work[36], work[35], 6'b0, work[34:30]} :
              cnt == 2'd1 ? {3'b0, work[29:20]} :
              cnt == 2'd2 ? {3'b0, work[19:10]} : {3'b0, work[9:0]};
        cmd_data = state == SEND  ? {work[47:42], work[41:37], 4'b0001, {1'b0, cnt} + 3'd1, ~front_buf, msg} :
                   state == FLUSH ? {11'b0, 4'b1111, 3'b0, ~front_buf, 13'b0} : 32'b0;
    end
endmodule

// File: doc/sprite_cmd_sequencer.md
Name: sprite_cmd_sequencer

Overview:
- Write side of the 32-bit sprite command-word interface consumed by the display sub-components (ground, sprites, blocks).
- Holds a table of NUM_ENTRIES sprite descriptors loaded by the host, and serializes them into command words once per frame on frame_start.
- Writes go to the back ping/pong buffer; the frame ends with a flush word that swaps buffers.

Parameters:
- NUM_ENTRIES, 8, descriptor table depth (power of 2, ≥2).
- IDX_W, $clog2(NUM_ENTRIES), table index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ld_en  in  1  write one table entry this cycle.
- ld_idx  in  IDX_W  entry index.
- ld_data  in  49  packed entry: [48] enable, [47:42] sub_comp, [41:37] child_comp, [36] visible, [35] flip, [34:30] pattern, [29:20] x, [19:10] y, [9:0] shift.
- frame_start  in  1  single-cycle request to emit one frame.
- cmd_data  out  32  command word.
- cmd_valid  out  1  cmd_data is valid.
- cmd_ready  in  1  consumer accepts the word.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when the flush word is accepted.
- frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy and a request is already pending.
- front_buf  out  1  buffer currently displayed.

Behaviour:
- Word format:
  - [31:26] sub_comp, [25:21] child_comp, [20:17] info, [16:14] type, [13] pp_selc, [12:0] msg.
  - Normal write: info=4'b0001, pp_selc=~front_buf.
  - Type 1 msg: [12] visible, [11] flip, [10:5] 0, [4:0] pattern.
  - Types 2/3/4 msg: [12:10] 0, [9:0] x / y / shift.
  - Flush word: info=4'b1111, pp_selc=~front_buf, all other fields 0.
- Reset (async, reset=0):
  - State IDLE; cmd_valid=0; cmd_data=0; busy=0; frame_done=0; frame_overrun=0; front_buf=0.
  - All table enable bits cleared; pending flag cleared.
  - Reset mid-frame abandons the frame and emits no flush.
- States: IDLE, FETCH, SEND, FLUSH.
  - IDLE: frame_start=1 → FETCH with idx=0, busy=1.
  - FETCH (one cycle): capture table[idx] into the working register.
    - enable=1 → SEND with field counter=1.
    - enable=0 → idx+1, stay in FETCH; after the last entry go to FLUSH.
  - SEND: cmd_valid=1, word built from the working register and field counter.
    - On cmd_valid&&cmd_ready: counter 1→2→3→4.
    - After type 4 is accepted: idx+1 → FETCH, or → FLUSH after the last entry.
  - FLUSH: cmd_valid=1 with the flush word. On accept:
    - front_buf toggles; frame_done pulses.
    - pending → FETCH (idx=0, pending cleared); otherwise → IDLE, busy=0.
- Handshake:
  - cmd_data is stable while cmd_valid && !cmd_ready; cmd_valid never drops without acceptance.
  - With cmd_ready held high, one word per cycle.
- Latency: frame_start sampled at edge N → first cmd_valid after edge N+1 when entry 0 is enabled.
- Loads:
  - Allowed at any time and take effect on the next FETCH of that index.
  - A load to the entry captured in the same cycle is not seen this frame.
  - Same-index loads: last write wins.
- frame_start while busy:
  - Sets pending.
  - If pending is already set: frame_overrun pulses and the request is dropped (pending stays 1).
- All entries disabled: frame consists of the flush word only.

Optional Feature:
- SEQ_SKIP_HIDDEN_EN:
  - Defined: an enabled entry with visible=0 emits only its type-1 word, then advances.
  - Undefined: every enabled entry emits all four words regardless of visible.

Test Plan:
1. Reset; load idx0 = {en=1, sub=15, child=0, vis=1, flip=0, pat=0, x=100, y=368, shift=0}; frame_start; cmd_ready=1 → words 0x3C027000, 0x3C02A064, 0x3C02E170, 0x3C032000, then flush 0x001E2000; frame_done; front_buf=1.
2. Second frame, same table → the same words with bit13=0 (e.g. 0x3C025000, flush 0x001E0000); front_buf=0.
3. cmd_ready toggled 0/1 randomly → cmd_data is unchanged across stall cycles and word order/count is identical to test 1.
4. frame_start twice during a frame, then again → one pending frame is run back-to-back, and exactly one frame_overrun pulse occurs.
5. All entries disabled, frame_start → after NUM_ENTRIES FETCH cycles the single flush word 0x001E2000 is emitted.
6. Assert reset mid-SEND → cmd_valid=0 immediately; busy=0; front_buf=0; the next frame emits nothing but the flush, because the table was cleared.
